seq_shift_unit: RTL
===================

// Module: seq_shift_unit
// PURPOSE
//   Multi-cycle, parametrised shift/rotate unit for the datapath ALU.
//   - Modes: logical right, arithmetic right, logical left, rotate right, rotate left.
//   - Shifts up to STEP bit positions per clock; start/done handshake to the control unit.
//   - Result is held stable until the next accepted start.
// PARAMETERS
//   WIDTH    32               operand/result width, >= 2
//   SHAMT_W  $clog2(WIDTH)    shift-amount bits used (5 at WIDTH=32)
//   STEP     1                max bit positions per cycle; power of 2, 1..WIDTH
// PORTS
//   clk      in   1        single clock, rising edge
//   clr      in   1        synchronous, active-high reset
//   start    in   1        request; sampled only in IDLE
//   mode     in   3        000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 reserved
//   operand  in   WIDTH    value to shift; latched on accepted start
//   shiftBy  in   WIDTH    shift amount; only shiftBy[SHAMT_W-1:0] used, upper bits ignored
//   busy     out  1        high in SHIFT and DONE
//   done     out  1        one-cycle pulse; result valid
//   result   out  WIDTH    shifted value; held until next accepted start
// BEHAVIOUR
//   - Reset: clr high at edge -> state IDLE; busy=0, done=0, result=0, count=0.
//     Aborts an in-flight operation. clr has priority over start.
//   - FSM states: IDLE, SHIFT, DONE.
//   - IDLE + start: latch operand, mode, and count=shiftBy[SHAMT_W-1:0].
//     count==0 or reserved mode -> DONE (result = operand); else -> SHIFT.
//   - SHIFT: each edge, shift working reg by k = min(STEP, count), count -= k.
//     When count reaches 0 -> DONE.
//   - DONE: done=1 for exactly one cycle, result = working reg; next edge -> IDLE.
//   - Latency: done is high ceil(n/STEP)+1 cycles after the start edge (n = amount).
//     n=0 -> 1 cycle.
//   - start while busy: ignored, no queueing. start on the cycle done is high is ignored.
//     The next start is accepted one cycle later, in IDLE.
//   - Fill rules:
//     - SHR/SHL fill with 0.
//     - SHRA replicates the latched MSB on every step.
//     - ROR/ROL wrap the bits shifted out; n=WIDTH-1 is max, no modulo beyond SHAMT_W.
//   - Inputs are don't-care outside the start-accept cycle; changes mid-op have no effect.
// CONFIGURATION
//   SHIFTER_FLAGS_EN defined: adds output ports zero (1) and cout (1).
//     - Both update when done is asserted; reset to 0.
//     - zero = (result == 0).
//     - cout = last bit shifted/rotated out; 0 when n=0 or mode is reserved.
//   Not defined: ports absent, no flag logic.
// STRUCTURE
//   - Package shifter_pkg: mode encodings (MODE_SHR..MODE_ROL), FSM state encodings,
//     and the STEP legality check as an elaboration-time assertion.
//   - Sub-module shift_step: combinational shift by k (0..STEP) for the given mode.
//     Also returns the last bit out. Instantiated once, on the working register.
// TESTING
//   - SHR, operand=32'hF000_000F, shiftBy=4, STEP=1 -> done after 5 cycles,
//     result=32'h0F00_0000.
//   - SHRA, operand=32'h8000_0000, shiftBy=31, STEP=4 -> done after 9 cycles,
//     result=32'hFFFF_FFFF.
//   - ROL, operand=32'h8000_0001, shiftBy=32'h0000_0021 (uses 1), STEP=1
//     -> result=32'h0000_0003 in 2 cycles.
//   - shiftBy=0, any mode -> done 1 cycle after start, result=operand.
//     A start pulsed while busy is ignored; busy/done timing unchanged.
//   - clr asserted mid-SHIFT with a 20-bit SHL in flight -> next cycle busy=0, done=0, result=0.
//     A new start after that completes normally.
//   - SHIFTER_FLAGS_EN, SHL 32'h8000_0000 by 1 -> result=0, zero=1, cout=1.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings and elaboration helpers for the multi-cycle shift/rotate unit.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_SHR  = 3'b000,
        MODE_SHRA = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // STEP must be a power of two in 1..WIDTH; checked when the top elaborates.
    function automatic bit step_ok(input int step, input int width);
        return (step >= 1) && (step <= width) && ((step & (step - 1)) == 0);
    endfunction

    function automatic bit mode_valid(input logic [2:0] m);
        return m <= 3'b100;
    endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Start/done request bus between the control unit (master) and the shifter (slave).
// SHIFTER_FLAGS_EN adds the zero/cout result flags.
interface seq_shift_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] shiftBy;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef SHIFTER_FLAGS_EN
    logic             zero;
    logic             cout;

    modport master (output start, mode, operand, shiftBy,
                    input  busy, done, result, zero, cout);
    modport slave  (input  start, mode, operand, shiftBy,
                    output busy, done, result, zero, cout);
`else
    modport master (output start, mode, operand, shiftBy,
                    input  busy, done, result);
    modport slave  (input  start, mode, operand, shiftBy,
                    output busy, done, result);
`endif
endinterface

// File: rtl/shift_step.sv
// Combinational shift/rotate by k (0..STEP) positions; cout_o is the last bit moved out.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       mode_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] data_o,
    output logic             cout_o
);

    always_comb begin
        data_o = data_i;
        cout_o = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k_i)) begin
                case (mode_i)
                    MODE_SHR: begin
                        cout_o = data_o[0];
                        data_o = {1'b0, data_o[WIDTH-1:1]};
                    end
                    MODE_SHRA: begin
                        cout_o = data_o[0];
                        data_o = {data_o[WIDTH-1], data_o[WIDTH-1:1]};
                    end
                    MODE_SHL: begin
                        cout_o = data_o[WIDTH-1];
                        data_o = {data_o[WIDTH-2:0], 1'b0};
                    end
                    MODE_ROR: begin
                        cout_o = data_o[0];
                        data_o = {data_o[0], data_o[WIDTH-1:1]};
                    end
                    MODE_ROL: begin
                        cout_o = data_o[WIDTH-1];
                        data_o = {data_o[WIDTH-2:0], data_o[WIDTH-1]};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP positions per clock, start/done handshake.
// Optional SHIFTER_FLAGS_EN adds registered zero/cout flags on the bus.
module seq_shift_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic            clk,
    input  logic            clr,
    seq_shift_unit_if.slave bus
);

    localparam int            KW     = $clog2(STEP + 1);
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    if (!step_ok(STEP, WIDTH)) begin : g_bad_step
        $error("seq_shift_unit: STEP must be a power of two in 1..WIDTH");
    end

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   result_q;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_data;
    logic               step_cout;
    logic               busy, done;

    logic [SHAMT_W-1:0] shamt;
    logic               unused_shift_hi;
    assign shamt           = bus.shiftBy[SHAMT_W-1:0];
    assign unused_shift_hi = ^bus.shiftBy[WIDTH-1:SHAMT_W];

    // Final partial step takes only what is left of the count.
    assign k = (32'(cnt_q) < STEP) ? KW'(cnt_q) : STEP_K;

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
        .data_i (work_q),
        .mode_i (mode_q),
        .k_i    (k),
        .data_o (step_data),
        .cout_o (step_cout)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)
                         state_d = (shamt == '0 || !mode_valid(bus.mode)) ? S_DONE : S_SHIFT;
            S_SHIFT: if (cnt_q == SHAMT_W'(k)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (state_q == S_IDLE && bus.start) begin
            work_d = bus.operand;
            cnt_d  = shamt;
            mode_d = bus.mode;
        end else if (state_q == S_SHIFT) begin
            work_d = step_data;
            cnt_d  = cnt_q - SHAMT_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            work_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= '0;
            result_q <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            // Result only moves on entry to DONE, so it holds until the next op finishes.
            if (state_d == S_DONE) result_q <= work_d;
        end
    end

`ifdef SHIFTER_FLAGS_EN
    logic last_q, last_d;
    logic zero_q, cout_q;

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && bus.start) last_d = 1'b0;
        else if (state_q == S_SHIFT)        last_d = step_cout;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_q <= 1'b0;
            zero_q <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            last_q <= last_d;
            if (state_d == S_DONE) begin
                zero_q <= (work_d == '0);
                cout_q <= last_d;
            end
        end
    end

    assign bus.zero = zero_q;
    assign bus.cout = cout_q;
`else
    logic unused_cout;
    assign unused_cout = step_cout;
`endif

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;

endmodule
